// File: rtl/ber_checker_pkg.sv
// Shared defaults and FSM state encoding for the BER checker slice.
package ber_checker_pkg;

   localparam int unsigned NB_DELAY_DEF = 9;
   localparam int unsigned NB_WIN_DEF   = 9;
   localparam int unsigned NB_CNT_DEF   = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCKED = 2'd2
   } ber_state_e;

endpackage

// File: rtl/ber_delay_line.sv
// Reference-bit delay line with a selectable tap; tap 0 is the live input bit.
module ber_delay_line
   import ber_checker_pkg::*;
#(
   parameter int unsigned NB_DELAY = NB_DELAY_DEF
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_shift,
   input  logic                i_bit,
   input  logic [NB_DELAY-1:0] i_sel,
   output logic                o_bit
);

   localparam int unsigned DEPTH = 2**NB_DELAY;

   // Tap 0 is combinational, so only DEPTH-1 history bits need storage.
   logic [DEPTH-2:0] line_q;
   logic [DEPTH-1:0] taps;

   assign taps  = {line_q, i_bit};
   assign o_bit = taps[i_sel];

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         line_q <= '0;
      end else if (i_shift) begin
         line_q <= taps[DEPTH-2:0];
      end
   end

endmodule

// File: rtl/ber_checker.sv
// Bit-error-rate checker: searches the reference delay that aligns with the
// received stream, then accumulates saturating error/bit counts while locked.
module ber_checker
   import ber_checker_pkg::*;
#(
   parameter int unsigned NB_DELAY = NB_DELAY_DEF,
   parameter int unsigned NB_WIN   = NB_WIN_DEF,
   parameter int unsigned NB_CNT   = NB_CNT_DEF
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic                i_enable,
   input  logic                i_clear,
   input  logic                i_bit_ref,
   input  logic                i_bit_rx,
   output logic                o_aligned,
   output logic [NB_DELAY-1:0] o_delay,
   output logic [NB_CNT-1:0]   o_err_count,
   output logic [NB_CNT-1:0]   o_bit_count
);

   localparam logic [NB_WIN:0] WIN_HALF = (NB_WIN+1)'(2**(NB_WIN-1));

   ber_state_e          state_q;
   logic                aligned_q;
   logic [NB_DELAY-1:0] delay_q;
   logic [NB_WIN-1:0]   win_cnt_q;
   logic [NB_WIN:0]     win_err_q;
   logic [NB_WIN:0]     win_err_d;
   logic [NB_CNT-1:0]   err_q;
   logic [NB_CNT-1:0]   err_d;
   logic [NB_CNT-1:0]   bit_q;
   logic [NB_CNT-1:0]   bit_d;
   logic [NB_DELAY-1:0] delay_inc;
   logic                strobe;
   logic                tap;
   logic                cmp;
   logic                win_end;

   assign strobe = i_valid & i_enable;

   ber_delay_line #(
      .NB_DELAY(NB_DELAY)
   ) u_delay_line (
      .clock  (clock),
      .i_reset(i_reset),
      .i_shift(strobe),
      .i_bit  (i_bit_ref),
      .i_sel  (delay_q),
      .o_bit  (tap)
   );

   // win_err_d includes the current strobe so the window-ending strobe counts.
   always_comb begin
      cmp       = tap ^ i_bit_rx;
      win_end   = &win_cnt_q;
      win_err_d = win_err_q + (NB_WIN+1)'(cmp);
      err_d     = (&err_q) ? err_q : err_q + NB_CNT'(cmp);
      bit_d     = (&bit_q) ? bit_q : bit_q + NB_CNT'(1);
      delay_inc = delay_q + NB_DELAY'(1);
   end

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         aligned_q <= 1'b0;
         delay_q   <= '0;
         win_cnt_q <= '0;
         win_err_q <= '0;
         err_q     <= '0;
         bit_q     <= '0;
      end else if (i_clear) begin
         state_q   <= ST_SEARCH;
         aligned_q <= 1'b0;
         delay_q   <= '0;
         win_cnt_q <= '0;
         win_err_q <= '0;
         err_q     <= '0;
         bit_q     <= '0;
      end else if (strobe) begin
         case (state_q)
            ST_IDLE: begin
               state_q   <= ST_SEARCH;
               delay_q   <= '0;
               win_cnt_q <= '0;
               win_err_q <= '0;
            end
            ST_SEARCH: begin
               win_cnt_q <= win_cnt_q + NB_WIN'(1);
               win_err_q <= win_end ? '0 : win_err_d;
               if (win_end) begin
                  if (win_err_d == '0) begin
                     state_q   <= ST_LOCKED;
                     aligned_q <= 1'b1;
                  end else begin
                     delay_q <= delay_inc;
                  end
               end
            end
            ST_LOCKED: begin
               err_q     <= err_d;
               bit_q     <= bit_d;
               win_cnt_q <= win_cnt_q + NB_WIN'(1);
               win_err_q <= win_end ? '0 : win_err_d;
               if (win_end && (win_err_d > WIN_HALF)) begin
                  state_q   <= ST_SEARCH;
                  aligned_q <= 1'b0;
                  delay_q   <= delay_inc;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               aligned_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_aligned   = aligned_q;
   assign o_delay     = delay_q;
   assign o_err_count = err_q;
   assign o_bit_count = bit_q;

endmodule

// File: tb/tb_ber_checker.sv
// Self-checking bench for ber_checker: directed alignment scenarios plus
// randomized traffic, all compared against a queue-based behavioural model.
module tb_ber_checker;

   localparam int unsigned NB_DELAY = 4;
   localparam int unsigned NB_WIN   = 3;
   localparam int unsigned NB_CNT   = 6;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned WIN      = 8;
   localparam longint unsigned CMAX = 63;

   logic                clock = 1'b0;
   logic                i_reset;
   logic                i_valid;
   logic                i_enable;
   logic                i_clear;
   logic                i_bit_ref;
   logic                i_bit_rx;
   logic                o_aligned;
   logic [NB_DELAY-1:0] o_delay;
   logic [NB_CNT-1:0]   o_err_count;
   logic [NB_CNT-1:0]   o_bit_count;

   ber_checker #(
      .NB_DELAY(NB_DELAY),
      .NB_WIN  (NB_WIN),
      .NB_CNT  (NB_CNT)
   ) dut (
      .clock      (clock),
      .i_reset    (i_reset),
      .i_valid    (i_valid),
      .i_enable   (i_enable),
      .i_clear    (i_clear),
      .i_bit_ref  (i_bit_ref),
      .i_bit_rx   (i_bit_rx),
      .o_aligned  (o_aligned),
      .o_delay    (o_delay),
      .o_err_count(o_err_count),
      .o_bit_count(o_bit_count)
   );

   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_errs   = 0;

   // Behavioural model state
   bit              m_started;
   bit              m_locked;
   int unsigned     m_delay;
   int unsigned     m_win_n;
   int unsigned     m_win_err;
   longint unsigned m_err;
   longint unsigned m_bit;
   bit              m_hist[$];

   // Stimulus source: PRBS9 and its own transmit history
   logic [8:0] prbs_s;
   bit         txh[$];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string pfx);
      check_eq({pfx, "_aligned"}, 64'(o_aligned), 64'(m_locked));
      check_eq({pfx, "_delay"}, 64'(o_delay), 64'(m_delay));
      check_eq({pfx, "_err"}, 64'(o_err_count), m_err);
      check_eq({pfx, "_bits"}, 64'(o_bit_count), m_bit);
   endtask

   task automatic m_reset();
      m_started = 1'b0;
      m_locked  = 1'b0;
      m_delay   = 0;
      m_win_n   = 0;
      m_win_err = 0;
      m_err     = 0;
      m_bit     = 0;
      m_hist.delete();
      repeat (DEPTH) m_hist.push_back(1'b0);
   endtask

   task automatic model_step(input bit v, input bit en, input bit clr, input bit rb, input bit rx);
      bit q;
      bit mism;
      q    = v && en;
      mism = 1'b0;
      if (q) begin
         m_hist.push_front(rb);
         void'(m_hist.pop_back());
         mism = m_hist[m_delay] ^ rx;
      end
      if (clr) begin
         m_started = 1'b1;
         m_locked  = 1'b0;
         m_delay   = 0;
         m_win_n   = 0;
         m_win_err = 0;
         m_err     = 0;
         m_bit     = 0;
      end else if (q) begin
         if (!m_started) begin
            m_started = 1'b1;
            m_delay   = 0;
            m_win_n   = 0;
            m_win_err = 0;
         end else begin
            if (m_locked) begin
               m_bit = (m_bit < CMAX) ? m_bit + 1 : CMAX;
               m_err = (m_err + mism < CMAX) ? m_err + mism : CMAX;
            end
            m_win_n++;
            m_win_err += mism;
            if (m_win_n == WIN) begin
               if (!m_locked) begin
                  if (m_win_err == 0) m_locked = 1'b1;
                  else m_delay = (m_delay + 1) % DEPTH;
               end else if (m_win_err > WIN / 2) begin
                  m_locked = 1'b0;
                  m_delay  = (m_delay + 1) % DEPTH;
               end
               m_win_n   = 0;
               m_win_err = 0;
            end
         end
      end
   endtask

   task automatic tick(input bit v, input bit en, input bit clr, input bit rb, input bit rx);
      i_valid   = v;
      i_enable  = en;
      i_clear   = clr;
      i_bit_ref = rb;
      i_bit_rx  = rx;
      @(posedge clock);
      model_step(v, en, clr, rb, rx);
      #1;
      check_outputs("cyc");
   endtask

   task automatic strobe(input bit rb, input bit rx, input bit clr);
      repeat (3) tick(1'b0, 1'b1, 1'b0, 1'($urandom), 1'($urandom));
      tick(1'b1, 1'b1, clr, rb, rx);
   endtask

   task automatic prbs_restart();
      prbs_s = 9'h1FF;
      txh.delete();
      repeat (DEPTH) txh.push_back(1'b0);
   endtask

   task automatic prbs_step(output bit b);
      b      = prbs_s[8] ^ prbs_s[4];
      prbs_s = {prbs_s[7:0], b};
      txh.push_front(b);
      void'(txh.pop_back());
   endtask

   // rx = reference delayed by d strobes, optionally inverted or forced to 0
   task automatic send(input int unsigned d, input bit inv, input bit zero, input bit clr);
      bit b;
      bit rx;
      prbs_step(b);
      rx = zero ? 1'b0 : (txh[d] ^ inv);
      strobe(b, rx, clr);
   endtask

   task automatic do_reset();
      i_reset  = 1'b1;
      i_valid  = 1'b0;
      i_clear  = 1'b0;
      i_enable = 1'b1;
      #2;
      m_reset();
      check_outputs("rst");
      @(posedge clock);
      #1;
      check_outputs("rst_hold");
      i_reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      bit          b;
      bit          rx;
      bit          v;
      bit          en;
      bit          clr;
      int unsigned n;
      int unsigned dsel;

      i_bit_ref = 1'b0;
      i_bit_rx  = 1'b0;
      do_reset();

      // Alignment at delay 5 after six windows plus the IDLE strobe
      prbs_restart();
      for (int i = 0; i <= 48; i++) begin
         send(5, 1'b0, 1'b0, 1'b0);
         if (i == 47) check_eq("lock5_early", 64'(o_aligned), 64'd0);
      end
      check_eq("lock5_aligned", 64'(o_aligned), 64'd1);
      check_eq("lock5_delay", 64'(o_delay), 64'd5);
      check_eq("lock5_err", 64'(o_err_count), 64'd0);

      // Three inverted strobes while locked
      for (int i = 0; i < 7; i++) begin
         send(5, (i >= 2 && i < 5), 1'b0, 1'b0);
         check_eq("inv_bits", 64'(o_bit_count), 64'(i + 1));
         check_eq("inv_aligned", 64'(o_aligned), 64'd1);
      end
      check_eq("inv_err", 64'(o_err_count), 64'd3);

      // Constant-zero rx drops lock and steps to delay 6
      n = 0;
      while (o_aligned && n < 64) begin
         send(5, 1'b0, 1'b1, 1'b0);
         n++;
      end
      check_eq("drop_aligned", 64'(o_aligned), 64'd0);
      check_eq("drop_delay", 64'(o_delay), 64'd6);
      check_eq("drop_bits", 64'(o_bit_count), 64'(7 + n));

      // Delay-15 search walks every delay, then wraps to 0 and relocks
      do_reset();
      prbs_restart();
      for (int i = 0; i <= 128; i++) begin
         send(15, 1'b0, 1'b0, 1'b0);
         if (i > 0 && i < 128 && (i % 8) == 0) begin
            check_eq("walk_delay", 64'(o_delay), 64'(i / 8));
            check_eq("walk_aligned", 64'(o_aligned), 64'd0);
         end
      end
      check_eq("lock15_aligned", 64'(o_aligned), 64'd1);
      check_eq("lock15_delay", 64'(o_delay), 64'd15);
      n = 0;
      while (o_aligned && n < 200) begin
         send(0, 1'b0, 1'b0, 1'b0);
         n++;
      end
      check_eq("wrap_delay", 64'(o_delay), 64'd0);
      n = 0;
      while (!o_aligned && n < 20) begin
         send(0, 1'b0, 1'b0, 1'b0);
         n++;
      end
      check_eq("relock0_aligned", 64'(o_aligned), 64'd1);
      check_eq("relock0_delay", 64'(o_delay), 64'd0);

      // Reset mid-lock: IDLE strobe, then one full clean window
      do_reset();
      for (int i = 0; i <= 8; i++) begin
         send(0, 1'b0, 1'b0, 1'b0);
         if (i == 7) check_eq("rst_nolock", 64'(o_aligned), 64'd0);
      end
      check_eq("rst_relock", 64'(o_aligned), 64'd1);

      // Clear coinciding with an erroring window end wins; SEARCH needs no IDLE strobe
      for (int i = 0; i < 8; i++) send(0, 1'b1, 1'b0, (i == 7));
      check_eq("clr_aligned", 64'(o_aligned), 64'd0);
      check_eq("clr_delay", 64'(o_delay), 64'd0);
      check_eq("clr_err", 64'(o_err_count), 64'd0);
      check_eq("clr_bits", 64'(o_bit_count), 64'd0);
      for (int i = 0; i < 8; i++) begin
         send(0, 1'b0, 1'b0, 1'b0);
         if (i == 6) check_eq("clr_nolock", 64'(o_aligned), 64'd0);
      end
      check_eq("clr_relock", 64'(o_aligned), 64'd1);

      // Exactly half the window in error keeps lock and drives both counters to saturation
      for (int i = 0; i < 16 * WIN; i++) send(0, (m_win_n < 4), 1'b0, 1'b0);
      check_eq("sat_aligned", 64'(o_aligned), 64'd1);
      check_eq("sat_err", 64'(o_err_count), CMAX);
      check_eq("sat_bits", 64'(o_bit_count), CMAX);

      // Randomized traffic: sparse strobes, freezes, clears, resets, bit flips
      dsel = 3;
      for (int c = 0; c < 1500; c++) begin
         if ((c % 300) == 0) dsel = $urandom_range(DEPTH - 1, 0);
         if ($urandom_range(999, 0) < 3) do_reset();
         v   = ($urandom_range(2, 0) == 0);
         en  = ($urandom_range(9, 0) != 0);
         clr = ($urandom_range(99, 0) == 0);
         if (v && en) begin
            prbs_step(b);
            rx = txh[dsel] ^ ($urandom_range(15, 0) == 0);
         end else begin
            b  = 1'($urandom);
            rx = 1'($urandom);
         end
         tick(v, en, clr, b, rx);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter NB_DELAY, default 9, width of the candidate-delay index; delay line depth 2**NB_DELAY reference bits.
REQ-002 Parameter NB_WIN, default 9, width of the window counter; one alignment window is 2**NB_WIN valid strobes.
REQ-003 Parameter NB_CNT, default 64, width of the error and bit accumulators.
REQ-004 clock  in  1  single system clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_valid  in  1  one-cycle sample strobe from the control stage; all datapath state advances only when high.
REQ-007 i_enable  in  1  low: hold all state and counters (freeze); high: run.
REQ-008 i_clear  in  1  synchronous request: zero the counters and restart alignment search at delay 0.
REQ-009 i_bit_ref  in  1  transmitted reference bit (PRBS), sampled on i_valid.
REQ-010 i_bit_rx  in  1  received/decided bit, sampled on i_valid.
REQ-011 o_aligned  out  1  high while in LOCKED.
REQ-012 o_delay  out  NB_DELAY  currently selected or tested delay.
REQ-013 o_err_count  out  NB_CNT  accumulated bit errors while LOCKED.
REQ-014 o_bit_count  out  NB_CNT  accumulated compared bits while LOCKED.

Function
REQ-015 On each i_valid with i_enable high, i_bit_ref SHALL shift into a 2**NB_DELAY-deep delay line; the tap at index o_delay is the compared reference (index 0 = current-cycle i_bit_ref).
REQ-016 Compare result SHALL be tap XOR i_bit_rx, evaluated only on qualified strobes (i_valid and i_enable).
REQ-017 FSM states: IDLE, SEARCH, LOCKED; IDLE is the reset state.
REQ-018 IDLE -> SEARCH on the first qualified strobe; o_delay = 0, window counters zero.
REQ-019 SEARCH: count errors over one window of 2**NB_WIN qualified strobes at the current delay.
REQ-020 End of SEARCH window with zero errors SHALL enter LOCKED on the next clock, keeping o_delay.
REQ-021 End of SEARCH window with any error SHALL increment o_delay modulo 2**NB_DELAY (wrap from max to 0) and start a new window; search never terminates on its own.
REQ-022 LOCKED: each qualified strobe SHALL increment o_bit_count by 1 and o_err_count by the compare result.
REQ-023 Accumulators SHALL saturate at all-ones; no wrap.
REQ-024 LOCKED SHALL also count window errors; window end with errors greater than 2**(NB_WIN-1) SHALL return to SEARCH at o_delay+1 (mod), accumulators retained.
REQ-025 i_clear SHALL take priority over every other event in the same cycle, including a window end: accumulators zeroed, o_delay = 0, state SEARCH, window counters zeroed.
REQ-026 i_enable low SHALL freeze delay line, FSM, and counters regardless of i_valid; i_clear still acts.
REQ-027 o_aligned, o_delay and counters SHALL be registered, updated the clock after the triggering strobe (latency 1).
REQ-028 The strobe ending a window SHALL itself be compared and counted within that window.

Reset
REQ-029 i_reset high SHALL immediately force: state IDLE, o_aligned 0, o_delay 0, o_err_count 0, o_bit_count 0, window counters 0, delay line all zeros.
REQ-030 Reset asserted mid-window or mid-lock SHALL discard all progress; release resumes from IDLE on the next qualified strobe.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (IDLE, SEARCH, LOCKED) and the default parameter values.
REQ-032 The reference delay line with selectable tap SHALL be one sub-module, ber_delay_line (params NB_DELAY; ports clock, i_reset, i_shift, i_bit, i_sel, o_bit).

Verification
REQ-033 Bench uses NB_DELAY=4, NB_WIN=3, control-stage strobe every 4 clocks, PRBS9 reference.
REQ-034 rx = ref delayed 5 strobes -> o_aligned high after 6 windows (48 strobes) plus 1 clock, o_delay = 5, o_err_count stays 0.
REQ-035 Locked, then invert rx for exactly 3 strobes -> o_err_count = 3, o_bit_count increments every strobe, o_aligned stays high.
REQ-036 Locked, then rx constant 0 -> errors exceed 4 in one window, o_aligned drops, o_delay advances to 6, counters retained.
REQ-037 rx delayed 15 strobes, start at 0 -> o_delay walks 0..15 and locks at 15; then delay 0 with no clear -> delay wraps 15 -> 0 and relocks.
REQ-038 i_reset pulsed mid-lock, and i_clear coincident with a window end -> all outputs 0, state IDLE / SEARCH respectively, no lock until a full clean window.
